// File: rtl/adder_measure_ctrl.sv
// ============================================================================
// Module   : adder_measure_ctrl
// Purpose  : Sequences one oscillation measurement of the instrumented adder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module adder_measure_ctrl #(
    parameter int CNT_W         = 32,
    parameter int WIN_W         = 16,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [31:0]      cfg_a,
    input  logic [31:0]      cfg_b,
    input  logic [WIN_W-1:0] cfg_window,
    input  logic             chain_out,
    input  logic [31:0]      adder_sum,
    output logic [31:0]      adder_a,
    output logic [31:0]      adder_b,
    output logic             adder_run,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] result_count,
    output logic [31:0]      result_sum,
    output logic             count_ovf
);

    localparam int c_set_w = (SETTLE_CYCLES <= 2) ? 1 : $clog2(SETTLE_CYCLES);

    localparam logic [2:0] c_idle    = 3'd0;
    localparam logic [2:0] c_load    = 3'd1;
    localparam logic [2:0] c_settle  = 3'd2;
    localparam logic [2:0] c_run     = 3'd3;
    localparam logic [2:0] c_capture = 3'd4;
    localparam logic [2:0] c_done    = 3'd5;

    localparam logic [CNT_W-1:0]   c_cnt_max  = '1;
    localparam logic [CNT_W-1:0]   c_cnt_one  = CNT_W'(1);
    localparam logic [WIN_W-1:0]   c_win_one  = WIN_W'(1);
    localparam logic [c_set_w-1:0] c_set_one  = c_set_w'(1);
    localparam logic [c_set_w-1:0] c_set_load = c_set_w'(SETTLE_CYCLES - 1);

    logic [2:0]         r_state;
    logic               r_sync1;
    logic               r_sync2;
    logic               r_sync3;
    logic [31:0]        r_op_a;
    logic [31:0]        r_op_b;
    logic [WIN_W-1:0]   r_window;
    logic [c_set_w-1:0] r_settle_cnt;
    logic [WIN_W-1:0]   r_win_cnt;
    logic [CNT_W-1:0]   r_count;
    logic               r_ovf;
    logic [31:0]        r_adder_a;
    logic [31:0]        r_adder_b;
    logic               r_run;
    logic               r_busy;
    logic               r_done;
    logic [CNT_W-1:0]   r_result_count;
    logic [31:0]        r_result_sum;
    logic               r_count_ovf;

    logic               w_edge;

    assign w_edge = r_sync2 & ~r_sync3;

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            r_state        <= c_idle;
            r_sync1        <= 1'b0;
            r_sync2        <= 1'b0;
            r_sync3        <= 1'b0;
            r_op_a         <= '0;
            r_op_b         <= '0;
            r_window       <= '0;
            r_settle_cnt   <= '0;
            r_win_cnt      <= '0;
            r_count        <= '0;
            r_ovf          <= 1'b0;
            r_adder_a      <= '0;
            r_adder_b      <= '0;
            r_run          <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_result_count <= '0;
            r_result_sum   <= '0;
            r_count_ovf    <= 1'b0;
        end else begin
            r_sync1 <= chain_out;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
            r_done  <= 1'b0;

            if (abort && (r_state != c_idle)) begin
                r_state <= c_idle;
                r_run   <= 1'b0;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    c_idle: begin
                        // abort in IDLE also masks a simultaneous start
                        if (start && !abort) begin
                            r_op_a   <= cfg_a;
                            r_op_b   <= cfg_b;
                            r_window <= cfg_window;
                            r_count  <= '0;
                            r_ovf    <= 1'b0;
                            r_busy   <= 1'b1;
                            r_state  <= c_load;
                        end
                    end
                    c_load: begin
                        r_adder_a    <= r_op_a;
                        r_adder_b    <= r_op_b;
                        r_settle_cnt <= c_set_load;
                        r_run        <= 1'b1;
                        r_state      <= c_settle;
                    end
                    c_settle: begin
                        if (r_settle_cnt == '0) begin
                            if (r_window == '0) begin
                                r_run   <= 1'b0;
                                r_state <= c_capture;
                            end else begin
                                r_win_cnt <= r_window - c_win_one;
                                r_state   <= c_run;
                            end
                        end else begin
                            r_settle_cnt <= r_settle_cnt - c_set_one;
                        end
                    end
                    c_run: begin
                        // ovf records an edge lost because the counter was full
                        if (w_edge) begin
                            if (r_count == c_cnt_max) begin
                                r_ovf <= 1'b1;
                            end else begin
                                r_count <= r_count + c_cnt_one;
                            end
                        end
                        if (r_win_cnt == '0) begin
                            r_run   <= 1'b0;
                            r_state <= c_capture;
                        end else begin
                            r_win_cnt <= r_win_cnt - c_win_one;
                        end
                    end
                    c_capture: begin
                        r_result_count <= r_count;
                        r_result_sum   <= adder_sum;
                        r_count_ovf    <= r_ovf;
                        r_done         <= 1'b1;
                        r_state        <= c_done;
                    end
                    c_done: begin
                        r_busy  <= 1'b0;
                        r_state <= c_idle;
                    end
                    default: begin
                        r_run   <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= c_idle;
                    end
                endcase
            end
        end
    end

    assign adder_a      = r_adder_a;
    assign adder_b      = r_adder_b;
    assign adder_run    = r_run;
    assign busy         = r_busy;
    assign done         = r_done;
    assign result_count = r_result_count;
    assign result_sum   = r_result_sum;
    assign count_ovf    = r_count_ovf;

endmodule

`default_nettype wire

// File: tb/tb_adder_measure_ctrl.sv
// ============================================================================
// Module   : tb_adder_measure_ctrl
// Purpose  : Directed self-checking bench for adder_measure_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_adder_measure_ctrl;

    logic        wb_clk_i   = 1'b0;
    logic        wb_rst_n   = 1'b0;
    logic        start      = 1'b0;
    logic        abort      = 1'b0;
    logic [31:0] cfg_a      = '0;
    logic [31:0] cfg_b      = '0;
    logic [15:0] cfg_window = '0;
    logic        chain_out  = 1'b0;

    logic [31:0] adder_a, adder_b, adder_sum, result_sum;
    logic [31:0] result_count;
    logic        adder_run, busy, done, count_ovf;

    logic [31:0] s_adder_a, s_adder_b, s_adder_sum, s_result_sum;
    logic [3:0]  s_result_count;
    logic        s_adder_run, s_busy, s_done, s_count_ovf;

    int n_vec    = 0;
    int n_err    = 0;
    int lat      = 0;
    int done_cnt = 0;
    int d0       = 0;
    int half_ns  = 20;
    logic busy_all;

    assign adder_sum   = adder_a + adder_b;
    assign s_adder_sum = s_adder_a + s_adder_b;

    adder_measure_ctrl u_dut (
        .wb_clk_i(wb_clk_i), .wb_rst_n(wb_rst_n), .start(start), .abort(abort),
        .cfg_a(cfg_a), .cfg_b(cfg_b), .cfg_window(cfg_window), .chain_out(chain_out),
        .adder_sum(adder_sum), .adder_a(adder_a), .adder_b(adder_b),
        .adder_run(adder_run), .busy(busy), .done(done),
        .result_count(result_count), .result_sum(result_sum), .count_ovf(count_ovf)
    );

    adder_measure_ctrl #(.CNT_W(4)) u_sat (
        .wb_clk_i(wb_clk_i), .wb_rst_n(wb_rst_n), .start(start), .abort(abort),
        .cfg_a(cfg_a), .cfg_b(cfg_b), .cfg_window(cfg_window), .chain_out(chain_out),
        .adder_sum(s_adder_sum), .adder_a(s_adder_a), .adder_b(s_adder_b),
        .adder_run(s_adder_run), .busy(s_busy), .done(s_done),
        .result_count(s_result_count), .result_sum(s_result_sum), .count_ovf(s_count_ovf)
    );

    initial forever #5 wb_clk_i = ~wb_clk_i;

    // loop oscillator, offset so its toggles never coincide with a clock edge
    initial begin
        #3;
        forever begin
            #(half_ns);
            chain_out = ~chain_out;
        end
    end

    always @(negedge wb_clk_i) if (done) done_cnt++;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic start_meas(input logic [31:0] a, input logic [31:0] b, input logic [15:0] w);
        @(negedge wb_clk_i);
        cfg_a = a; cfg_b = b; cfg_window = w; start = 1'b1;
        @(negedge wb_clk_i);
        start    = 1'b0;
        lat      = 1;
        busy_all = busy;
        check("run_in_load", {63'd0, adder_run}, 64'd0);
    endtask

    task automatic step_to(input int target);
        while (lat < target) begin
            @(negedge wb_clk_i);
            lat++;
            if (!busy) busy_all = 1'b0;
        end
    endtask

    // inject > 0 fires extra start pulses and cfg changes mid-measurement
    task automatic wait_done(input int bound, input int inject);
        while (!done && lat < bound) begin
            @(negedge wb_clk_i);
            lat++;
            if (!busy) busy_all = 1'b0;
            if (lat == 2) check("run_in_settle", {63'd0, adder_run}, 64'd1);
            if (inject > 0 && lat == inject) begin
                start = 1'b1; cfg_a = 32'd1000; cfg_window = 16'd5;
            end
            if (inject > 0 && lat == inject + 2) start = 1'b0;
        end
        start = 1'b0;
        check("done_seen", {63'd0, done}, 64'd1);
    endtask

    task automatic finish_meas();
        @(negedge wb_clk_i);
        check("busy_after_done", {63'd0, busy}, 64'd0);
        check("done_one_cycle", {63'd0, done}, 64'd0);
    endtask

    initial begin
        #12;
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_run", {63'd0, adder_run}, 64'd0);
        check("rst_count", {32'd0, result_count}, 64'd0);
        check("rst_sum", {32'd0, result_sum}, 64'd0);
        check("rst_ovf", {63'd0, count_ovf}, 64'd0);
        check("rst_adder_a", {32'd0, adder_a}, 64'd0);
        @(negedge wb_clk_i);
        wb_rst_n = 1'b1;

        // basic: period 4, window 40
        half_ns = 20;
        d0 = done_cnt;
        start_meas(32'd5, 32'd7, 16'd40);
        wait_done(200, 0);
        check("basic_latency", 64'(lat), 64'd47);
        check("basic_busy_span", {63'd0, busy_all}, 64'd1);
        check("basic_sum", {32'd0, result_sum}, 64'd12);
        check("basic_count", {32'd0, result_count}, 64'd10);
        check("basic_ovf", {63'd0, count_ovf}, 64'd0);
        check("basic_adder_b", {32'd0, adder_b}, 64'd7);
        finish_meas();
        check("basic_done_pulses", 64'(done_cnt - d0), 64'd1);

        // saturation: period 2, window 100 -> 50 edges
        half_ns = 10;
        start_meas(32'd1, 32'd1, 16'd100);
        wait_done(300, 0);
        check("sat_latency", 64'(lat), 64'd107);
        check("sat_count4", {60'd0, s_result_count}, 64'd15);
        check("sat_ovf4", {63'd0, s_count_ovf}, 64'd1);
        check("sat_count32", {32'd0, result_count}, 64'd50);
        check("sat_ovf32", {63'd0, count_ovf}, 64'd0);
        finish_meas();
        half_ns = 20;
        start_meas(32'd2, 32'd2, 16'd8);
        wait_done(100, 0);
        check("post_sat_latency", 64'(lat), 64'd15);
        check("post_sat_count4", {60'd0, s_result_count}, 64'd2);
        check("post_sat_ovf4", {63'd0, s_count_ovf}, 64'd0);
        finish_meas();

        // zero window skips RUN
        start_meas(32'd3, 32'd4, 16'd0);
        wait_done(50, 0);
        check("zero_latency", 64'(lat), 64'd7);
        check("zero_count", {32'd0, result_count}, 64'd0);
        check("zero_sum", {32'd0, result_sum}, 64'd7);
        finish_meas();

        // abort in the 5th RUN cycle
        d0 = done_cnt;
        start_meas(32'd100, 32'd200, 16'd40);
        step_to(10);
        abort = 1'b1;
        @(negedge wb_clk_i);
        abort = 1'b0;
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_run", {63'd0, adder_run}, 64'd0);
        repeat (60) @(negedge wb_clk_i);
        check("abort_no_done", 64'(done_cnt - d0), 64'd0);
        check("abort_sum_kept", {32'd0, result_sum}, 64'd7);
        check("abort_count_kept", {32'd0, result_count}, 64'd0);

        // abort in IDLE masks a same-cycle start
        @(negedge wb_clk_i);
        start = 1'b1; abort = 1'b1;
        @(negedge wb_clk_i);
        start = 1'b0; abort = 1'b0;
        check("idle_abort_blocks_start", {63'd0, busy}, 64'd0);

        // start and cfg changes while busy are ignored
        d0 = done_cnt;
        start_meas(32'd9, 32'd10, 16'd20);
        wait_done(200, 10);
        check("busy_start_latency", 64'(lat), 64'd27);
        check("busy_start_sum", {32'd0, result_sum}, 64'd19);
        finish_meas();
        check("busy_start_done_pulses", 64'(done_cnt - d0), 64'd1);

        // asynchronous reset mid-RUN, off the clock edge
        start_meas(32'd1, 32'd2, 16'd40);
        step_to(10);
        #2 wb_rst_n = 1'b0;
        #1;
        check("arst_busy", {63'd0, busy}, 64'd0);
        check("arst_run", {63'd0, adder_run}, 64'd0);
        check("arst_sum", {32'd0, result_sum}, 64'd0);
        check("arst_count", {32'd0, result_count}, 64'd0);
        check("arst_adder_a", {32'd0, adder_a}, 64'd0);
        @(negedge wb_clk_i);
        wb_rst_n = 1'b1;
        start_meas(32'd2, 32'd3, 16'd8);
        wait_done(100, 0);
        check("post_rst_latency", 64'(lat), 64'd15);
        check("post_rst_sum", {32'd0, result_sum}, 64'd5);
        check("post_rst_count", {32'd0, result_count}, 64'd2);
        finish_meas();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/adder_measure_ctrl.md
Name: adder_measure_ctrl

Overview:
Measurement sequencer for the instrumented ripple adder. It latches operands, drives them into the adder and enables the adder's oscillation loop, then counts loop transitions on chain_out over a programmable window of clock cycles. At the end of the window it captures the transition count and the adder sum, and signals completion. It sits between the LA/IO configuration registers and the instrumented adder instance inside the wrapper.

Parameters:
CNT_W, 32, width of the transition counter and result_count
WIN_W, 16, width of cfg_window
SETTLE_CYCLES, 4, cycles in SETTLE (oscillator start-up plus synchronizer fill); minimum 2

Ports:
wb_clk_i  input  1  system clock
wb_rst_n  input  1  reset, asynchronous, active-low
start  input  1  request a measurement; sampled only in IDLE
abort  input  1  cancel the current measurement
cfg_a  input  32  operand A
cfg_b  input  32  operand B
cfg_window  input  WIN_W  measurement window length in clock cycles
chain_out  input  1  adder loop output; asynchronous to wb_clk_i
adder_sum  input  32  adder sum output
adder_a  output  32  operand A to the adder
adder_b  output  32  operand B to the adder
adder_run  output  1  enables the adder oscillation loop
busy  output  1  high in every state except IDLE
done  output  1  one-cycle completion pulse
result_count  output  CNT_W  rising edges counted in the last completed window
result_sum  output  32  adder_sum captured at the end of the last completed window
count_ovf  output  1  counter saturated in the last completed window

Behaviour:
- Reset (async assert, sync release): state=IDLE; all outputs 0; counters and synchronizers 0.
- chain_out passes through a 2-flop synchronizer plus one history flop. A rising edge is sync2 & ~sync3.
- State flow: IDLE -> LOAD -> SETTLE -> RUN -> CAPTURE -> DONE -> IDLE.
- IDLE: start=1 latches cfg_a, cfg_b and cfg_window, clears the edge counter and the ovf flag, then moves to LOAD. adder_run=0.
- LOAD (1 cycle): adder_a/adder_b take the latched operands and hold them until the next LOAD. adder_run=0.
- SETTLE (SETTLE_CYCLES cycles): adder_run=1. Edges are not counted.
- RUN (window cycles): adder_run=1. Each detected edge increments the counter. The counter saturates at 2^CNT_W-1 and sets the internal ovf flag. A latched window of 0 skips RUN (SETTLE goes directly to CAPTURE).
- CAPTURE (1 cycle): result_count <= counter, result_sum <= adder_sum, count_ovf <= ovf. adder_run=0.
- DONE (1 cycle): done=1, then IDLE.
- Latency: with start high in cycle T, done is high in cycle T+1+1+SETTLE_CYCLES+window+1.
- start while busy: ignored, no queuing. Changes to cfg_* while busy have no effect.
- abort=1 in any non-IDLE state: IDLE on the next edge, adder_run=0, no done pulse, result_* and count_ovf keep their previous values. abort has priority over all other transitions. abort in IDLE: no effect, and start is ignored in that same cycle.
- Reset mid-operation: immediate IDLE, all outputs 0, including result_* values.
- result_* and count_ovf stay stable between CAPTUREs.

Test Plan:
- Basic: reset, cfg_a=5, cfg_b=7, window=40, chain_out square wave with a 4-clock period -> result_count=10 (+/-1 for edge phase), result_sum=12, done pulses once at T+47, busy high T+1..T+47.
- Saturation: CNT_W=4, window=100, chain_out period 2 -> result_count=15, count_ovf=1. A following run with window=8 and period 4 -> result_count=2, count_ovf=0.
- Zero window: window=0, chain_out toggling -> result_count=0, done at T+1+1+SETTLE_CYCLES+1 (T+7 with the default).
- Abort: abort asserted in the 5th RUN cycle -> busy=0 and adder_run=0 on the next cycle, no done, result_* unchanged from the prior run.
- Busy start: extra start pulses and cfg_a changes during RUN -> exactly one done, result_sum uses the originally latched operands.
- Async reset: wb_rst_n low mid-RUN (not on a clock edge) -> all outputs 0 immediately. After release, a new start completes normally.
